alu_arbiter: RTL

Shares one combinational ALU + flag unit (N-bit operands, 4-bit op select, Neg/Z/O/Ca flags) between two requesters, e.g. the pixel decrypt engine and the key/address generator. Accepts operation requests over valid/ready handshakes, picks one requester per slot with round-robin priority, and drives the shared ALU from registered operands. It then captures result and flags into registers and returns them to the winning requester over a valid/ready response handshake.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/rr_arb2.sv | 21 ++
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, flag bit positions and FSM states.
package alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0010;
  localparam logic [OP_W-1:0] OP_DIV = 4'b0011;
  localparam logic [OP_W-1:0] OP_AND = 4'b0100;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0101;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0110;
  localparam logic [OP_W-1:0] OP_NOT = 4'b0111;
  localparam logic [OP_W-1:0] OP_SHL = 4'b1000;
  localparam logic [OP_W-1:0] OP_SHR = 4'b1001;
  localparam logic [OP_W-1:0] OP_CMP = 4'b1010;
  localparam logic [OP_W-1:0] OP_MAX = OP_CMP;

  localparam int unsigned FLAG_NEG = 3;
  localparam int unsigned FLAG_Z   = 2;
  localparam int unsigned FLAG_O   = 1;
  localparam int unsigned FLAG_CA  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; after an advancing grant the pointer moves to the other port.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_prio,
  input  logic       i_advance,
  output logic [1:0] o_grant_c,
  output logic       o_prio_c
);

  always_comb begin
    o_grant_c = i_req;
    o_prio_c  = i_prio;
    if (i_req == 2'b11) begin
      o_grant_c = i_prio ? 2'b10 : 2'b01;
    end
    if (i_advance && (|o_grant_c)) begin
      o_prio_c = o_grant_c[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters with round-robin grant
// and a registered result/flag response returned to the winning port.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  input  logic              p1_req_valid,
  output logic              p0_req_ready,
  output logic              p1_req_ready,
  input  logic [OP_W-1:0]   p0_req_op,
  input  logic [OP_W-1:0]   p1_req_op,
  input  logic [N-1:0]      p0_req_a,
  input  logic [N-1:0]      p0_req_b,
  input  logic [N-1:0]      p1_req_a,
  input  logic [N-1:0]      p1_req_b,
  output logic              p0_rsp_valid,
  output logic              p1_rsp_valid,
  input  logic              p0_rsp_ready,
  input  logic              p1_rsp_ready,
  output logic [N-1:0]      rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err,
  output logic [OP_W-1:0]   alu_sel,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  input  logic [N-1:0]      alu_result,
  input  logic              alu_neg,
  input  logic              alu_z,
  input  logic              alu_o,
  input  logic              alu_ca
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_prio;
  logic              w_prio_nxt;
  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_advance;
  logic              w_owner_rsp_ready;
  logic [1:0]        r_rsp_valid;
  logic [1:0]        w_rsp_valid_nxt;
  logic              r_owner;
  logic              r_illegal;
  logic [OP_W-1:0]   r_sel;
  logic [N-1:0]      r_a;
  logic [N-1:0]      r_b;
  logic [N-1:0]      r_result;
  logic [FLAG_W-1:0] r_flags;
  logic              r_err;
  logic [OP_W-1:0]   w_op;
  logic [N-1:0]      w_a;
  logic [N-1:0]      w_b;

  assign w_req = {p1_req_valid, p0_req_valid};

  rr_arb2 u_rr_arb2 (
    .i_req     (w_req),
    .i_prio    (r_prio),
    .i_advance (w_advance),
    .o_grant_c (w_grant),
    .o_prio_c  (w_prio_nxt)
  );

  assign w_op = w_grant[1] ? p1_req_op : p0_req_op;
  assign w_a  = w_grant[1] ? p1_req_a  : p0_req_a;
  assign w_b  = w_grant[1] ? p1_req_b  : p0_req_b;

  assign w_owner_rsp_ready = r_owner ? p1_rsp_ready : p0_rsp_ready;

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt     = r_state;
    w_advance       = 1'b0;
    w_rsp_valid_nxt = r_rsp_valid;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_advance   = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt     = ST_RESP;
        w_rsp_valid_nxt = r_owner ? 2'b10 : 2'b01;
      end
      ST_RESP: begin
        if (w_owner_rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 2'b00;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_rsp_valid_nxt = 2'b00;
      end
    endcase
  end

  // Acceptance is visible in the same cycle but suppressed while reset is held
  assign p0_req_ready = w_advance & w_grant[0] & ~rst;
  assign p1_req_ready = w_advance & w_grant[1] & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_prio      <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_owner     <= 1'b0;
      r_illegal   <= 1'b0;
      r_sel       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_flags     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prio      <= w_prio_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      if (w_advance) begin
        r_owner   <= w_grant[1];
        r_illegal <= ~op_legal(w_op);
        r_sel     <= op_legal(w_op) ? w_op : OP_ADD;
        r_a       <= w_a;
        r_b       <= w_b;
      end
      // Illegal ops still run the ALU on op 0 but their outcome is discarded
      if (r_state == ST_EXEC) begin
        r_result <= r_illegal ? '0 : alu_result;
        r_flags  <= r_illegal ? '0 : {alu_neg, alu_z, alu_o, alu_ca};
        r_err    <= r_illegal;
      end
    end
  end

  assign p0_rsp_valid = r_rsp_valid[0];
  assign p1_rsp_valid = r_rsp_valid[1];
  assign rsp_result   = r_result;
  assign rsp_flags    = r_flags;
  assign rsp_err      = r_err;
  assign alu_sel      = r_sel;
  assign alu_a        = r_a;
  assign alu_b        = r_b;

endmodule
